// File: rtl/rgb2yuv_share_arb_if.sv
// Pixel offer channel from one source into the shared colour-space converter.
// The source drives valid and R/G/B and holds them until ready is returned.
interface rgb2yuv_share_arb_if #(
  parameter int DW = 10
);
  logic          valid;
  logic [DW-1:0] r;
  logic [DW-1:0] g;
  logic [DW-1:0] b;
  logic          ready;

  modport master (output valid, r, g, b, input ready);
  modport slave  (input valid, r, g, b, output ready);
endinterface

// File: rtl/rgb2yuv_share_arb.sv
// Shares one RGB-to-YCbCr converter between two pixel sources. Arbitration is
// round-robin with a bounded burst; every issued pixel carries an owner tag
// through a shift register matched to the converter latency, and the tag at
// the pipe head steers the converter result back to its owner.
module rgb2yuv_share_arb #(
  parameter int DW          = 10,
  parameter int CSC_LATENCY = 5,
  parameter int MAX_BURST   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  rgb2yuv_share_arb_if.slave        i_rq0,
  rgb2yuv_share_arb_if.slave        i_rq1,
  output logic [DW-1:0]             o_csc_red,
  output logic [DW-1:0]             o_csc_green,
  output logic [DW-1:0]             o_csc_blue,
  output logic                      o_csc_valid_in,
  input  logic [DW-1:0]             i_csc_y,
  input  logic [DW-1:0]             i_csc_cb,
  input  logic [DW-1:0]             i_csc_cr,
  input  logic                      i_csc_valid_out,
  output logic [DW-1:0]             o_o0_y,
  output logic [DW-1:0]             o_o0_cb,
  output logic [DW-1:0]             o_o0_cr,
  output logic                      o_o0_valid,
  output logic [DW-1:0]             o_o1_y,
  output logic [DW-1:0]             o_o1_cb,
  output logic [DW-1:0]             o_o1_cr,
  output logic                      o_o1_valid,
  output logic [15:0]               o_cnt0,
  output logic [15:0]               o_cnt1,
  input  logic                      i_cnt_clr,
  output logic                      o_tag_err
);

  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t                 r_state;
  state_t                 w_nxt_state;
  logic                   r_last;
  logic [7:0]             r_burst;
  logic [7:0]             w_nxt_burst;
  logic [7:0]             w_burst_inc;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic [CSC_LATENCY-1:0] r_tag_vld_p;
  logic [CSC_LATENCY-1:0] r_tag_id_p;
  logic                   w_head_vld;
  logic                   w_head_id;
  logic                   w_route;
  logic [15:0]            r_cnt0;
  logic [15:0]            r_cnt1;
  logic                   r_tag_err;

  assign w_burst_inc = (r_burst < BURST_MAX) ? 8'(r_burst + 8'd1) : BURST_MAX;

  // Grant decision and next state; grants are forced off while reset is held.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_nxt_state = r_state;
    w_nxt_burst = r_burst;
    case (r_state)
      S_IDLE: begin
        if (i_rq0.valid && (!i_rq1.valid || r_last)) w_gnt0 = 1'b1;
        else if (i_rq1.valid)                        w_gnt1 = 1'b1;
      end
      S_OWN0: begin
        if (i_rq0.valid && !(i_rq1.valid && r_burst == BURST_MAX)) w_gnt0 = 1'b1;
        else if (i_rq1.valid)                                       w_gnt1 = 1'b1;
      end
      S_OWN1: begin
        if (i_rq1.valid && !(i_rq0.valid && r_burst == BURST_MAX)) w_gnt1 = 1'b1;
        else if (i_rq0.valid)                                       w_gnt0 = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
    if (w_gnt0) begin
      w_nxt_state = S_OWN0;
      w_nxt_burst = (r_state == S_OWN0) ? w_burst_inc : 8'd1;
    end else if (w_gnt1) begin
      w_nxt_state = S_OWN1;
      w_nxt_burst = (r_state == S_OWN1) ? w_burst_inc : 8'd1;
    end else begin
      w_nxt_state = S_IDLE;
      w_nxt_burst = 8'd0;
    end
  end

  // Arbiter state, burst length and last-granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_burst <= 8'd0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_burst <= w_nxt_burst;
      if (w_gnt0 || w_gnt1) r_last <= w_gnt1;
    end
  end

  assign i_rq0.ready    = w_gnt0;
  assign i_rq1.ready    = w_gnt1;
  assign o_csc_valid_in = w_gnt0 | w_gnt1;
  assign o_csc_red      = w_gnt0 ? i_rq0.r : (w_gnt1 ? i_rq1.r : '0);
  assign o_csc_green    = w_gnt0 ? i_rq0.g : (w_gnt1 ? i_rq1.g : '0);
  assign o_csc_blue     = w_gnt0 ? i_rq0.b : (w_gnt1 ? i_rq1.b : '0);

  // Owner tag pipe: stage 0 takes this cycle's issue, the last stage lines up
  // with the converter output of the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld_p <= '0;
      r_tag_id_p  <= '0;
    end else begin
      for (int i = CSC_LATENCY - 1; i > 0; i--) begin
        r_tag_vld_p[i] <= r_tag_vld_p[i-1];
        r_tag_id_p[i]  <= r_tag_id_p[i-1];
      end
      r_tag_vld_p[0] <= o_csc_valid_in;
      r_tag_id_p[0]  <= w_gnt1;
    end
  end

  assign w_head_vld = r_tag_vld_p[CSC_LATENCY-1];
  assign w_head_id  = r_tag_id_p[CSC_LATENCY-1];
  // A disagreement between converter and tag leaves one of the two low, so
  // routing drops out automatically in that cycle.
  assign w_route    = i_csc_valid_out & w_head_vld;

  assign o_o0_valid = w_route & ~w_head_id;
  assign o_o1_valid = w_route & w_head_id;
  assign o_o0_y     = o_o0_valid ? i_csc_y  : '0;
  assign o_o0_cb    = o_o0_valid ? i_csc_cb : '0;
  assign o_o0_cr    = o_o0_valid ? i_csc_cr : '0;
  assign o_o1_y     = o_o1_valid ? i_csc_y  : '0;
  assign o_o1_cb    = o_o1_valid ? i_csc_cb : '0;
  assign o_o1_cr    = o_o1_valid ? i_csc_cr : '0;

  // Sticky converter/tag disagreement flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_tag_err <= 1'b0;
    else if (i_csc_valid_out != w_head_vld)  r_tag_err <= 1'b1;
  end

  // Per-requester grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else if (i_cnt_clr) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else begin
      if (w_gnt0) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_gnt1) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign o_cnt0    = r_cnt0;
  assign o_cnt1    = r_cnt1;
  assign o_tag_err = r_tag_err;

endmodule

// File: doc/rgb2yuv_share_arb.md
Name: rgb2yuv_share_arb

Overview:
- Shares one 10-bit RGB-to-YCbCr colour-space-converter pipeline between two pixel sources, for example the CCD capture path and a test-pattern or overlay path.
- Arbitrates round-robin with a bounded burst length and drives the converter's R/G/B and data_valid_in.
- Tags each issued pixel and routes the converter's Y/Cb/Cr result back to the owning requester when the converter's data_valid_out rises CSC_LATENCY cycles later.
- Sits directly in front of the converter top, between the capture front end and the downstream frame-buffer writers.

Parameters:
- DW, 10, pixel component width; also the converter input and output width.
- CSC_LATENCY, 5, cycles from the converter's data_valid_in high to its matching data_valid_out high. Legal range 1..16.
- MAX_BURST, 8, maximum consecutive grants to one requester while the other requester is waiting. Legal range 1..255.

Ports:
- Clock  in  1  single clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- rq0_valid  in  1  requester 0 offers a pixel.
- rq0_r, rq0_g, rq0_b  in  DW each  requester 0 pixel components.
- rq0_ready  out  1  requester 0 pixel accepted this cycle.
- rq1_valid, rq1_r, rq1_g, rq1_b, rq1_ready  same directions, widths and meanings as requester 0.
- csc_red, csc_green, csc_blue  out  DW each  converter inputs.
- csc_valid_in  out  1  converter data_valid_in.
- csc_y, csc_cb, csc_cr  in  DW each  converter outputs.
- csc_valid_out  in  1  converter data_valid_out.
- o0_y, o0_cb, o0_cr  out  DW each  result for requester 0.
- o0_valid  out  1  result for requester 0 valid.
- o1_y, o1_cb, o1_cr, o1_valid  same as o0_*, for requester 1.
- cnt0, cnt1  out  16 each  pixels granted per requester; wrap at 16 bits.
- cnt_clr  in  1  synchronous clear of cnt0 and cnt1.
- tag_err  out  1  sticky flag: converter and tag pipeline disagree.

Behaviour:
- Reset: asynchronous, active-high. While Reset is high:
  - all outputs are 0 (rq*_ready, csc_*, o*_*, cnt*, tag_err);
  - the tag pipeline is cleared;
  - the arbiter is in IDLE with last=1, so requester 0 has priority first;
  - burst_cnt is 0.
  - Reset asserted mid-operation discards in-flight tags; results already inside the converter are not routed out.
- Grant is combinational from rq*_valid and the registered state. At most one grant per cycle.
- Handshake: rqN_ready=1 only when rqN is granted. A transfer occurs when valid and ready are both high. Requesters hold their data stable until ready.
- Datapath: csc_valid_in = rq0_ready | rq1_ready. csc_red/green/blue = the granted requester's components, or 0 when there is no grant. No output backpressure; o*_valid consumers must accept.
- State machine (registered state plus burst_cnt):
  - IDLE: no valid requests, so no grant.
    - One requester valid: grant it, burst_cnt=1, go to OWN0 or OWN1.
    - Both valid: grant the requester that is not `last`.
  - OWNn, requester n still valid:
    - Other requester not valid: keep granting n, burst_cnt saturates at MAX_BURST.
    - Other requester valid and burst_cnt<MAX_BURST: keep granting n, burst_cnt+1.
    - Other requester valid and burst_cnt==MAX_BURST: grant the other this cycle, move to its OWN state, burst_cnt=1.
  - OWNn, requester n drops valid:
    - Other requester valid: grant the other this cycle, burst_cnt=1.
    - Otherwise: go to IDLE.
  - `last` updates to the granted requester on every grant.
- Tag pipeline: a CSC_LATENCY-deep shift register of {vld, id}, loaded each cycle with {csc_valid_in, granted id}. The tag issued at cycle t is at the pipe head at t+CSC_LATENCY.
- Routing is combinational from the pipe head:
  - If csc_valid_out and head.vld: oID_valid=1 and oID_y/cb/cr = csc_y/cb/cr; the other requester's valid is 0.
  - Non-routed data outputs are 0.
- Error: if csc_valid_out != head.vld in any cycle, tag_err sets and stays set until Reset. Routing is suppressed in that cycle.
- Counters:
  - cntN increments on each requester-N transfer and wraps 0xFFFF→0.
  - cnt_clr has priority over an increment in the same cycle.

Test Plan:
- Reset=1 with random inputs → all outputs 0. Release Reset, rq0 only streams 20 pixels → rq0_ready=1 all 20 cycles; o0_valid exactly 5 cycles after each grant; cnt0=20, cnt1=0.
- Both requesters valid continuously, MAX_BURST=8 → grant pattern 0×8, 1×8, 0×8…; cnt0 and cnt1 each 32 after 64 cycles; no gaps in csc_valid_in.
- Alternating single pixels, rq0 R/G/B=0x3FF,0,0 and rq1 R/G/B=0,0x3FF,0 → each converter result appears on the correct o*_ with the correct owner; o0_valid and o1_valid never both 1.
- Inject csc_valid_out=1 with the tag pipe empty → tag_err=1 from the next cycle onward; no o*_valid. Only Reset clears tag_err.
- Assert Reset 2 cycles after 3 grants, release, then send 1 pixel from rq1 → no stale outputs; exactly one o1_valid, 5 cycles after the grant; state starts in IDLE with priority to rq0.
- Preload cnt0=0xFFFF, then 1 transfer → cnt0=0. cnt_clr in the same cycle as a transfer → cnt0=0.
